// File: rtl/frame_max_pkg.sv
// Shared types and width helpers for the frame-maximum engine.
package frame_max_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } fm_state_t;

    // Bits needed to name one lane of a beat (at least one bit).
    function automatic int unsigned lane_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Bits needed for a global sample index within a frame.
    function automatic int unsigned idx_w(input int unsigned lanes, input int unsigned max_beats);
        return (lanes * max_beats > 1) ? $clog2(lanes * max_beats) : 1;
    endfunction

    // Bits needed for a beat count that saturates at max_beats.
    function automatic int unsigned cnt_w(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/frame_max_scheduler_lane_argmax.sv
// Recursive combinational arg-max over the lanes of one beat.
// The lower part is the largest power of two below LANES, so an odd element
// at any level rides up unchanged; ties resolve to the lower lane.
module lane_argmax
    import frame_max_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic [LANES*WIDTH-1:0]       data,
    output logic [WIDTH-1:0]             max_val,
    output logic [lane_w(LANES)-1:0]     max_lane
);

    localparam int unsigned LW = lane_w(LANES);

    if (LANES == 1) begin : g_leaf
        assign max_val  = data;
        assign max_lane = '0;
    end else begin : g_node
        localparam int unsigned LO_N = 1 << ($clog2(LANES) - 1);
        localparam int unsigned HI_N = LANES - LO_N;

        logic [WIDTH-1:0]        lo_max;
        logic [WIDTH-1:0]        hi_max;
        logic [lane_w(LO_N)-1:0] lo_lane;
        logic [lane_w(HI_N)-1:0] hi_lane;
        logic                    hi_wins;

        lane_argmax #(.WIDTH(WIDTH), .LANES(LO_N)) u_lo (
            .data     (data[LO_N*WIDTH-1:0]),
            .max_val  (lo_max),
            .max_lane (lo_lane)
        );

        lane_argmax #(.WIDTH(WIDTH), .LANES(HI_N)) u_hi (
            .data     (data[LANES*WIDTH-1:LO_N*WIDTH]),
            .max_val  (hi_max),
            .max_lane (hi_lane)
        );

        // Upper half only wins on a strictly greater value.
        assign hi_wins  = $signed(hi_max) > $signed(lo_max);
        assign max_val  = hi_wins ? hi_max : lo_max;
        assign max_lane = hi_wins ? (LW'(LO_N) + LW'(hi_lane)) : LW'(lo_lane);
    end

endmodule

// File: rtl/frame_max_scheduler.sv
// Streaming frame-maximum engine: per-beat lane arg-max, running signed
// maximum and global index across a frame, result held until consumed.
module frame_max_scheduler
    import frame_max_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned LANES     = 4,
    parameter  int unsigned MAX_BEATS = 256,
    localparam int unsigned IDX_W     = idx_w(LANES, MAX_BEATS),
    localparam int unsigned CNT_W     = cnt_w(MAX_BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_max,
    output logic [IDX_W-1:0]       out_index,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   out_overflow
);

    localparam int unsigned LANE_W = lane_w(LANES);

    fm_state_t          state;
    fm_state_t          next_state;

    logic               first;
    logic               overflow;
    logic [CNT_W-1:0]   beat_cnt;
    logic [WIDTH-1:0]   run_max;
    logic [IDX_W-1:0]   run_idx;

    logic [WIDTH-1:0]   beat_max;
    logic [LANE_W-1:0]  beat_lane;
    logic               fire;
    logic               cnt_sat;
    logic               take_beat;
    logic [IDX_W-1:0]   cand_idx;
    logic [WIDTH-1:0]   merged_max;
    logic [IDX_W-1:0]   merged_idx;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    lane_argmax #(.WIDTH(WIDTH), .LANES(LANES)) u_argmax (
        .data     (in_data),
        .max_val  (beat_max),
        .max_lane (beat_lane)
    );

    // Merge the current beat into the running result.
    always_comb begin
        fire       = in_valid && in_ready;
        cnt_sat    = (beat_cnt == CNT_W'(MAX_BEATS));
        cand_idx   = cnt_sat ? '1
                             : IDX_W'(beat_cnt) * IDX_W'(LANES) + IDX_W'(beat_lane);
        take_beat  = first || ($signed(beat_max) > $signed(run_max));
        merged_max = take_beat ? beat_max : run_max;
        merged_idx = take_beat ? cand_idx : run_idx;
        cnt_next   = cnt_sat ? beat_cnt : beat_cnt + CNT_W'(1);
        ovf_next   = overflow || cnt_sat;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM: if (fire && in_last)         next_state = HOLD;
            HOLD:  if (out_valid && out_ready)  next_state = ACCUM;
            default:                            next_state = ACCUM;
        endcase
    end

    // Frame accumulators, output registers and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b0;
            first        <= 1'b1;
            overflow     <= 1'b0;
            beat_cnt     <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            out_valid    <= 1'b0;
            out_max      <= '0;
            out_index    <= '0;
            out_beats    <= '0;
            out_overflow <= 1'b0;
        end else begin
            in_ready <= (next_state == ACCUM);
            if (state == ACCUM && fire) begin
                if (in_last) begin
                    out_valid    <= 1'b1;
                    out_max      <= merged_max;
                    out_index    <= merged_idx;
                    out_beats    <= cnt_next;
                    out_overflow <= ovf_next;
                    first        <= 1'b1;
                    overflow     <= 1'b0;
                    beat_cnt     <= '0;
                end else begin
                    first        <= 1'b0;
                    overflow     <= ovf_next;
                    beat_cnt     <= cnt_next;
                    run_max      <= merged_max;
                    run_idx      <= merged_idx;
                end
            end else if (state == HOLD && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frame_max_scheduler.md
# frame_max_scheduler

Streaming frame-maximum engine: accepts a frame as a sequence of multi-lane beats over valid/ready, reduces each beat with a combinational lane arg-max tree, and accumulates a running signed maximum and its global index across the frame. It sits between a sample source and any consumer needing per-frame peak value and position (peak detection, normalisation). It sequences the combinational max-reduction datapath over time.

## Interface
- `WIDTH`, 8, sample width, two's-complement signed
- `LANES`, 4, samples per beat, ≥1
- `MAX_BEATS`, 256, beats per frame that can be indexed, ≥1
- Derived: `IDX_W = max(1, $clog2(LANES*MAX_BEATS))`, `CNT_W = $clog2(MAX_BEATS+1)`
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_data`  in  signed [WIDTH-1:0] x LANES  beat samples; lane 0 = lowest index
- `in_last`  in  1  final beat of frame
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_max`  out  signed WIDTH  frame maximum
- `out_index`  out  IDX_W  beat_number*LANES + lane of winning sample
- `out_beats`  out  CNT_W  beats in frame, saturating at MAX_BEATS
- `out_overflow`  out  1  frame exceeded MAX_BEATS beats

## Operation
- States: ACCUM, HOLD. Reset → ACCUM.
- ACCUM: `in_ready=1`, `out_valid=0`. Each accepted beat:
  - lane tree produces beat max and lane; ties → lowest lane.
  - first beat of frame (`first` flag set): running max/index loaded unconditionally.
  - later beats: update only if beat max > running max (strict signed); ties keep earlier sample, so the reported index is always the lowest global index of the maximum.
  - candidate index = beat_cnt*LANES + lane; if beat_cnt ≥ MAX_BEATS, index = all ones.
  - beat_cnt increments, saturating at MAX_BEATS; accepting a beat while beat_cnt == MAX_BEATS sets sticky overflow.
- Accepted beat with `in_last`: merged result (including this beat) loaded into output registers, `out_valid` ← 1, beat_cnt/overflow/first reset for next frame, → HOLD.
- HOLD: `in_ready=0`; outputs stable. `out_valid && out_ready` → `out_valid` ← 0, → ACCUM.
- `in_valid` low cycles inside a frame: no state change.
- Signed comparison throughout; no arithmetic on sample values; index multiply is constant-width IDX_W, truncation impossible below saturation.

## Timing
- Reset values: `in_ready=0` while `rst` high, 1 on first cycle after; `out_valid=0`, `out_max=0`, `out_index=0`, `out_beats=0`, `out_overflow=0`; running state and `first=1` cleared.
- `in_ready` is a registered/state-decoded output, not combinational on `out_ready`.
- Latency: result `out_valid` on the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle within a frame; minimum one cycle with `in_ready=0` per frame (HOLD), even with `out_ready` held high.
- `rst` mid-frame or in HOLD: partial frame and pending result discarded, no output produced.
- Single-beat frame (first beat with `in_last`): legal, result = that beat's arg-max.

## Structure
- Shared package `frame_max_pkg`: index/count width functions, state enum `fm_state_t` {ACCUM, HOLD}.
- Sub-module `lane_argmax`: parameterised (WIDTH, LANES) recursive pairwise combinational tree returning max value and lane index, ties to lower index; odd counts pass the last element up unchanged.
- Top holds the FSM, counters, running registers, output registers.

## Test plan
- Single beat {3,-5,7,7}, last → next cycle `out_max=7`, `out_index=2`, `out_beats=1`, `out_overflow=0`.
- Three beats {-128,-1,-2,-3},{-1,-1,-4,-9},{-50,-60,-70,-80} → `out_max=-1`, `out_index=1`, `out_beats=3`.
- Result pending, `out_ready=0` for 5 cycles → `in_ready=0`, outputs unchanged; handshake → `in_ready=1` next cycle; next frame's first beat accepted then.
- MAX_BEATS=4, LANES=4, 6-beat frame with 100 at beat 5 lane 2, others 0 → `out_max=100`, `out_index=15`, `out_beats=4`, `out_overflow=1`; next frame `out_overflow=0`.
- Two beats accepted, `rst` pulsed 1 cycle, then frame {1,2,3,4} last → single result `out_max=4`, `out_index=3`, `out_beats=1`.
- Beats of a 2-beat frame separated by 3 idle `in_valid=0` cycles → result identical to back-to-back delivery.
